mmio_interconnect: RTL and testbench

// - Parametrised memory-mapped bus fabric between the multicycle core's data port and N peripheral slaves.
// - Replaces the fixed combinational chip-select decoder and 7:1 read mux with a registered, handshaked transaction engine.
// - Adds per-slave wait states, a timeout and a bus-error response.

---
 rtl/mmio_interconnect_if.sv | 34 +++
 rtl/mmio_interconnect.sv | 194 +++++++++++++++++++
 tb/tb_mmio_interconnect.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mmio_interconnect_if.sv
// Bus bundle between the core data port, the MMIO fabric and its slaves.
// The fabric uses the slave modport; the core/peripheral side uses master.
interface mmio_interconnect_if #(
    parameter int N_SLAVES = 8,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32
);
    logic                         m_read;
    logic                         m_write;
    logic [ADDR_W-1:0]            m_addr;
    logic [DATA_W-1:0]            m_wdata;
    logic [DATA_W-1:0]            m_rdata;
    logic                         m_ready;
    logic                         m_err;
    logic [N_SLAVES-1:0]          s_cs;
    logic                         s_read;
    logic                         s_write;
    logic [ADDR_W-1:0]            s_addr;
    logic [DATA_W-1:0]            s_wdata;
    logic [N_SLAVES*DATA_W-1:0]   s_rdata;
    logic [N_SLAVES-1:0]          s_ready;

    modport slave (
        input  m_read, m_write, m_addr, m_wdata, s_rdata, s_ready,
        output m_rdata, m_ready, m_err,
        output s_cs, s_read, s_write, s_addr, s_wdata
    );

    modport master (
        output m_read, m_write, m_addr, m_wdata, s_rdata, s_ready,
        input  m_rdata, m_ready, m_err,
        input  s_cs, s_read, s_write, s_addr, s_wdata
    );
endinterface

// File: rtl/mmio_interconnect.sv
// Registered MMIO fabric: IDLE/ACCESS/RESP engine with wait states and timeout.
// Define MMIO_ERR_LOG_EN to build the error address/count log.
module mmio_interconnect #(
    parameter int N_SLAVES = 8,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SEL_LSB  = 12,
    parameter int SEL_W    = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    mmio_interconnect_if.slave bus,
    output logic [ADDR_W-1:0] err_addr,
    output logic [7:0]        err_count
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [N_SLAVES-1:0] cs_q, cs_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0]    idx_q, idx_d;

    logic [SEL_W-1:0]    req_idx;
    logic                req_ok;
    logic [N_SLAVES-1:0] req_onehot;
    logic [DATA_W-1:0]   sel_rdata;
    logic                sel_ready;
    logic                tmo_hit;

    assign req_idx = bus.m_addr[SEL_LSB+SEL_W-1:SEL_LSB];
    assign req_ok  = (32'(req_idx) < N_SLAVES);
    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

    always_comb begin
        req_onehot = '0;
        sel_rdata  = '0;
        sel_ready  = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            req_onehot[i] = (req_idx == SEL_W'(i));
            if (idx_q == SEL_W'(i)) begin
                sel_rdata = bus.s_rdata[i*DATA_W +: DATA_W];
                sel_ready = bus.s_ready[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.m_read || bus.m_write) begin
                    addr_d  = bus.m_addr;
                    wdata_d = bus.m_wdata;
                    idx_d   = req_idx;
                    cnt_d   = '0;
                end
                unique case (1'b1)
                    bus.m_read && bus.m_write: begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                    bus.m_read ^ bus.m_write: begin
                        if (req_ok) begin
                            state_d = ACCESS;
                            cs_d    = req_onehot;
                            rd_d    = bus.m_read;
                            wr_d    = bus.m_write;
                        end else begin
                            state_d = RESP;
                            ready_d = 1'b1;
                            err_d   = 1'b1;
                            rdata_d = '0;
                        end
                    end
                    default: ;
                endcase
            end
            ACCESS: begin
                // Only the selected slave's ready counts; it wins over timeout.
                if (sel_ready) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    rdata_d = rd_q ? sel_rdata : '0;
                    cs_d    = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else if (tmo_hit) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    cs_d    = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cs_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.s_cs    = cs_q;
    assign bus.s_read  = rd_q;
    assign bus.s_write = wr_q;
    assign bus.s_addr  = addr_q;
    assign bus.s_wdata = wdata_q;
    assign bus.m_rdata = rdata_q;
    assign bus.m_ready = ready_q;
    assign bus.m_err   = err_q;

`ifdef MMIO_ERR_LOG_EN
    logic [ADDR_W-1:0] elog_addr_q;
    logic [7:0]        elog_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            elog_addr_q <= '0;
            elog_cnt_q  <= '0;
        end else if (state_q == RESP && err_q) begin
            elog_addr_q <= addr_q;
            if (elog_cnt_q != 8'hFF) begin
                elog_cnt_q <= elog_cnt_q + 8'd1;
            end
        end
    end

    assign err_addr  = elog_addr_q;
    assign err_count = elog_cnt_q;
`else
    assign err_addr  = '0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_mmio_interconnect.sv
// Randomised transaction bench for mmio_interconnect against a
// transaction-level latency/response model.
module tb_mmio_interconnect;

    localparam int NS  = 8;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TMO = 15;

    logic          clk;
    logic          rst;
    logic [AW-1:0] err_addr;
    logic [7:0]    err_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [AW-1:0] m_eaddr = '0;
    int            m_ecnt  = 0;

    mmio_interconnect_if #(.N_SLAVES(NS), .DATA_W(DW), .ADDR_W(AW)) bus ();

    mmio_interconnect #(
        .N_SLAVES(NS), .DATA_W(DW), .ADDR_W(AW),
        .SEL_LSB(12), .SEL_W(4), .TIMEOUT(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_slaves(input logic [3:0] idx, input logic [31:0] sdata,
                                input bit rdy);
        for (int i = 0; i < NS; i++) begin
            if (i == int'(idx)) begin
                bus.s_rdata[i*DW +: DW] = sdata;
                bus.s_ready[i]          = rdy;
            end else begin
                bus.s_rdata[i*DW +: DW] = $urandom;
                bus.s_ready[i]          = 1'($urandom);
            end
        end
    endtask

    task automatic log_model(input bit e, input logic [31:0] a);
`ifdef MMIO_ERR_LOG_EN
        if (e) begin
            m_eaddr = a;
            if (m_ecnt < 255) m_ecnt++;
        end
`endif
    endtask

    // Called at a negedge while the fabric is idle; returns at a negedge, idle.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] sdata,
                           input int w);
        logic [3:0]  idx;
        bit          dec_err, tmo, exp_err, bad;
        int          exp_lat, exp_csc, got_lat, csc;
        logic [31:0] exp_rdata;
        idx       = addr[15:12];
        dec_err   = (rd && wr) || (int'(idx) >= NS);
        tmo       = !dec_err && (TMO != 0) && (w > TMO);
        exp_err   = dec_err || tmo;
        exp_lat   = dec_err ? 1 : (tmo ? TMO + 2 : w + 2);
        exp_csc   = dec_err ? 0 : (tmo ? TMO + 1 : w + 1);
        exp_rdata = (exp_err || !rd) ? 32'h0 : sdata;
        bus.m_read  = rd;
        bus.m_write = wr;
        bus.m_addr  = addr;
        bus.m_wdata = wdata;
        drive_slaves(idx, sdata, 1'($urandom));
        got_lat = 0;
        csc     = 0;
        bad     = 0;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.s_cs != '0) begin
                csc++;
                if (bus.s_cs != (8'(1) << idx) || bus.s_read != rd ||
                    bus.s_write != wr || bus.s_addr != addr ||
                    bus.s_wdata != wdata)
                    bad = 1;
            end
            if (bus.m_ready) begin
                got_lat = c;
                break;
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.m_read  = 1'b0;
                bus.m_write = 1'b0;
            end
            drive_slaves(idx, sdata, (c - 1) >= w);
        end
        chk("latency", 64'(got_lat), 64'(exp_lat));
        chk("m_err", 64'(bus.m_err), 64'(exp_err));
        chk("m_rdata", 64'(bus.m_rdata), 64'(exp_rdata));
        chk("cs_cycles", 64'(csc), 64'(exp_csc));
        chk("cs_stable", 64'(bad), 64'(0));
        bus.m_read  = 1'b0;
        bus.m_write = 1'b0;
        drive_slaves(idx, $urandom, 1'($urandom));
        log_model(exp_err, addr);
        @(posedge clk);
        @(negedge clk);
        chk("ready_pulse", 64'(bus.m_ready), 64'(0));
        chk("err_addr", 64'(err_addr), 64'(m_eaddr));
        chk("err_count", 64'(err_count), 64'(m_ecnt));
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_m_ready"}, 64'(bus.m_ready), 64'(0));
        chk({pfx, "_m_err"}, 64'(bus.m_err), 64'(0));
        chk({pfx, "_s_cs"}, 64'(bus.s_cs), 64'(0));
        chk({pfx, "_s_read"}, 64'(bus.s_read), 64'(0));
        chk({pfx, "_s_write"}, 64'(bus.s_write), 64'(0));
        chk({pfx, "_s_addr"}, 64'(bus.s_addr), 64'(0));
        chk({pfx, "_s_wdata"}, 64'(bus.s_wdata), 64'(0));
        chk({pfx, "_m_rdata"}, 64'(bus.m_rdata), 64'(0));
        chk({pfx, "_err_count"}, 64'(err_count), 64'(0));
        chk({pfx, "_err_addr"}, 64'(err_addr), 64'(0));
    endtask

    initial begin
        logic [31:0] a;
        int          k, w;
        rst         = 1'b0;
        bus.m_read  = 1'b0;
        bus.m_write = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.s_rdata = '0;
        bus.s_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        rst = 1'b1;
        @(negedge clk);

        run_txn(1, 0, 32'h0000_2004, 32'h0, 32'hDEAD_BEEF, 0);
        run_txn(0, 1, 32'h0000_5010, 32'h1234_5678, 32'hCAFE_0000, 3);
        run_txn(1, 0, 32'h0000_9000, 32'h0, 32'h1111_1111, 0);
        run_txn(1, 0, 32'h0000_0000, 32'h0, 32'h2222_2222, 1000);
        run_txn(1, 1, 32'h0000_3000, 32'h5555_AAAA, 32'h3333_3333, 0);
        run_txn(1, 0, 32'h0000_7ffc, 32'h0, 32'h4444_4444, TMO);
        run_txn(0, 1, 32'h0000_6000, 32'h9999_0000, 32'h0, TMO + 1);

        // Reset in the middle of a long access: no response, clean restart.
        bus.m_read  = 1'b1;
        bus.m_addr  = 32'h0000_1040;
        bus.m_wdata = 32'hABCD_0123;
        drive_slaves(4'd1, 32'h7777_7777, 1'b0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            drive_slaves(4'd1, 32'h7777_7777, 1'b0);
        end
        chk("pre_rst_cs", 64'(bus.s_cs), 64'(8'b0000_0010));
        rst         = 1'b0;
        bus.m_read  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        m_eaddr = '0;
        m_ecnt  = 0;
        chk_quiet("midrst");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.m_ready), 64'(0));
        run_txn(1, 0, 32'h0000_1008, 32'h0, 32'h8888_8888, 2);

        for (int t = 0; t < 60; t++) begin
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[15] = 1'b0;
            k = $urandom_range(0, 9);
            w = ($urandom_range(0, 5) == 0) ? $urandom_range(TMO - 1, TMO + 2)
                                            : $urandom_range(0, 4);
            if (k == 0) run_txn(1, 1, a, $urandom, $urandom, w);
            else if (k < 6) run_txn(1, 0, a, $urandom, $urandom, w);
            else run_txn(0, 1, a, $urandom, $urandom, w);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
